// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int N_DEF       = 4;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 1024;

    // Low bit of generator idx's byte inside the flattened txdata_in bus.
    function automatic int slice_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req scanning ptr, ptr+1, ... mod N.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    // Rotate the scan start to ptr; first hit wins.
    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter. One generator at a time
// gets the byte handshake; grant ends on its done pulse or a stall timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    input  logic [N*DW-1:0] txdata_in,
    input  logic [N-1:0]    ldtxdata_in,
    input  logic            txempty,
    output logic [N-1:0]    start_out,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    txempty_out,
    output logic [DW-1:0]   txdata,
    output logic            ldtxdata,
    output logic            busy,
    output logic            timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t     state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  cur;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   pick;
    logic           pick_vld;
    logic [PW-1:0]  pick_idx;
    logic [PW-1:0]  nxt_ptr;
    logic           granted;

    rr_picker #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    // One-hot pick to index, kept so the mux and ptr update need no re-encode.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    assign nxt_ptr = (cur == PW'(N - 1)) ? '0 : cur + 1'b1;
    assign granted = |gnt;

    // Zero-latency datapath so generator byte timing matches a direct hookup.
    assign txdata   = granted ? txdata_in[slice_lo(int'(cur), DW) +: DW] : '0;
    assign ldtxdata = granted & ldtxdata_in[cur];

    for (genvar i = 0; i < N; i++) begin : g_empty
        assign txempty_out[i] = txempty & gnt[i];
    end

    // Grant FSM with registered grant/start/busy/timeout outputs and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            start_out   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            cur         <= '0;
            cnt         <= '0;
        end else begin
            start_out   <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // txempty gate lets the previous owner's last byte drain.
                    if (pick_vld && txempty) begin
                        gnt       <= pick;
                        start_out <= pick;
                        busy      <= 1'b1;
                        cur       <= pick_idx;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    if (done[cur]) begin
                        // done wins over a coincident timeout.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= nxt_ptr;
                        state <= RELEASE;
                    end else if (txempty && !ldtxdata_in[cur]) begin
                        cnt <= (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            gnt         <= '0;
                            busy        <= 1'b0;
                            ptr         <= nxt_ptr;
                            timeout_err <= 1'b1;
                            state       <= RELEASE;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
